// File: rtl/alu_md_seq.sv
// EX-stage integer unit: single-cycle RV base ALU plus iterative radix-2 M-extension
// multiply/divide, behind a valid/ready handshake that stalls the pipe while busy.
module alu_md_seq #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            md_en,
  input  logic [3:0]      funct,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      rd_addr_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_o,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;

  typedef struct packed {
    logic [2:0] f3;
    logic [4:0] rd;
    logic       neg;   // negate the magnitude result at completion
    logic       spec;  // divide special case, answer already in spec_res
  } op_t;

  logic [1:0]        state;
  logic [SW-1:0]     cnt;
  op_t               op;
  logic [2*XLEN-1:0] pr;   // product, or {remainder, quotient}
  logic [XLEN-1:0]   opb;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]   spec_res;

  logic accept, last;
  assign in_ready  = !flush && (state == S_IDLE || (state == S_DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = state == S_DONE;
  assign busy      = state == S_MUL || state == S_DIV;
  assign last      = cnt == SW'(XLEN-1);

  // operand decode on the accepting cycle
  logic [2:0]      f3;
  logic [SW-1:0]   shamt;
  logic            s1_sgn, s2_sgn, s1_neg, s2_neg, div0, ovf;
  logic [XLEN-1:0] a_mag, b_mag, alu_res, sra_res, spec_val;

  assign f3    = funct[2:0];
  assign shamt = src2[SW-1:0];

  always_comb begin
    if (f3[2]) begin
      s1_sgn = !f3[0];
      s2_sgn = !f3[0];
    end else begin
      s1_sgn = f3 == 3'b001 || f3 == 3'b010;
      s2_sgn = f3 == 3'b001;
    end
  end

  assign s1_neg   = s1_sgn && src1[XLEN-1];
  assign s2_neg   = s2_sgn && src2[XLEN-1];
  assign a_mag    = s1_neg ? -src1 : src1;
  assign b_mag    = s2_neg ? -src2 : src2;
  assign div0     = src2 == '0;
  assign ovf      = !f3[0] && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1;
  assign spec_val = div0 ? (f3[1] ? src1 : '1) : (f3[1] ? '0 : src1);
  // kept separate so the shift stays signed regardless of the mux around it
  assign sra_res  = $signed(src1) >>> shamt;

  always_comb begin
    unique case (f3)
      3'b000:  alu_res = funct[3] ? src1 - src2 : src1 + src2;
      3'b001:  alu_res = src1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
      3'b100:  alu_res = src1 ^ src2;
      3'b101:  alu_res = funct[3] ? sra_res : src1 >> shamt;
      3'b110:  alu_res = src1 | src2;
      default: alu_res = src1 & src2;
    endcase
  end

  // one shift-add or restoring-subtract step per cycle
  logic [XLEN:0]     mul_sum, div_sh, div_try;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, mul_fix;
  logic [XLEN-1:0]   quo, rem, mul_out, div_out;

  assign mul_sum = {1'b0, pr[2*XLEN-1:XLEN]} + (pr[0] ? {1'b0, opb} : '0);
  assign mul_nxt = {mul_sum, pr[XLEN-1:1]};
  assign div_sh  = {pr[2*XLEN-1:XLEN], pr[XLEN-1]};
  assign div_try = div_sh - {1'b0, opb};
  assign div_nxt = div_try[XLEN] ? {div_sh[XLEN-1:0], pr[XLEN-2:0], 1'b0}
                                 : {div_try[XLEN-1:0], pr[XLEN-2:0], 1'b1};
  assign mul_fix = op.neg ? -mul_nxt : mul_nxt;
  assign mul_out = op.f3 == 3'b000 ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
  assign quo     = div_nxt[XLEN-1:0];
  assign rem     = div_nxt[2*XLEN-1:XLEN];

  always_comb begin
    if (op.spec)       div_out = spec_res;
    else if (op.f3[1]) div_out = op.neg ? -rem : rem;
    else               div_out = op.neg ? -quo : quo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      result    <= '0;
      rd_addr_o <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else if (accept) begin
      op.f3    <= f3;
      op.rd    <= rd_addr_i;
      op.neg   <= (f3[2] && f3[1]) ? s1_neg : (s1_neg ^ s2_neg);
      op.spec  <= div0 || ovf;
      spec_res <= spec_val;
      cnt      <= '0;
      if (!md_en) begin
        state     <= S_DONE;
        result    <= alu_res;
        rd_addr_o <= rd_addr_i;
      end else if (!f3[2]) begin
        state <= S_MUL;
        pr    <= {{XLEN{1'b0}}, b_mag};
        opb   <= a_mag;
      end else if (EARLY_OUT && (div0 || ovf)) begin
        state     <= S_DONE;
        result    <= spec_val;
        rd_addr_o <= rd_addr_i;
      end else begin
        state <= S_DIV;
        pr    <= {{XLEN{1'b0}}, a_mag};
        opb   <= b_mag;
      end
    end else begin
      unique case (state)
        S_MUL: begin
          pr  <= mul_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= S_DONE;
            result    <= mul_out;
            rd_addr_o <= op.rd;
          end
        end
        S_DIV: begin
          pr  <= div_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= S_DONE;
            result    <= div_out;
            rd_addr_o <= op.rd;
          end
        end
        S_DONE:  if (out_ready) state <= S_IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_md_seq.md
Name: alu_md_seq

Overview:
Parametrised next-generation integer execute unit for the RV32I/RV64I core. It keeps the existing single-cycle register/immediate ALU operations and adds the RISC-V M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), implemented as an iterative radix-2 datapath. It sits in the EX stage between the decode/operand-select logic and the EX/MEM register. It uses a valid/ready handshake so that the pipeline stalls while a multi-cycle operation is in flight.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64. Shift amount uses the low $clog2(XLEN) bits of src2.
EARLY_OUT, 1, when 1, divide-by-zero and signed-overflow divides complete with 1-cycle latency. When 0, they take the full iterative latency and return the same result.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
flush  in  1  synchronous kill of the in-flight or pending operation (branch mispredict/trap).
in_valid  in  1  operation offered.
in_ready  out  1  unit can accept an operation this cycle.
md_en  in  1  0 = base ALU op, 1 = M-extension op.
funct  in  4  md_en=0: [2:0] = RV funct3, [3] = instr[30] (SUB/SRA select). md_en=1: [2:0] = M funct3, [3] ignored.
src1  in  XLEN  operand 1 (rs1 data).
src2  in  XLEN  operand 2 (rs2 data or immediate; selected upstream).
rd_addr_i  in  5  destination register, carried with the op.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts the result.
result  out  XLEN  operation result.
rd_addr_o  out  5  destination register of the result.
busy  out  1  high in the MUL or DIV state.

Behaviour:
- Reset is synchronous and active-high. On rst: state=IDLE, out_valid=0, result=0, rd_addr_o=0, busy=0, iteration counter=0. rst overrides every other input, including a result in the middle of an operation.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready); it is forced to 0 when flush=1.
- Accept = in_valid && in_ready && !flush. The unit captures funct, md_en, operands and rd_addr_i on the accepting edge.
- Base ops (md_en=0) are ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND per RV semantics.
  - SUB and SRA are selected by funct[3].
  - SRA is a true arithmetic shift.
  - SLT and SLTU return 0 or 1, zero-extended.
  - Transition: accept -> DONE. out_valid is high after 1 clock (latency 1).
- MUL family: accept -> MUL.
  - Operands are converted to magnitudes with sign flags: MULH is signed×signed, MULHSU is signed×unsigned, MULHU and MUL are unsigned-correct.
  - The unit performs XLEN shift-add iterations into a 2·XLEN product, then goes to DONE and applies the sign fix-up.
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
  - Latency is XLEN+1 clocks from the accept edge to out_valid=1 (33 for XLEN=32).
- DIV family: accept -> DIV. The unit runs XLEN restoring-division iterations on magnitudes, then goes to DONE.
  - Quotient sign = sign(src1) XOR sign(src2). Remainder sign = sign(src1).
  - Latency is XLEN+1.
- Division special cases (results are independent of EARLY_OUT; with EARLY_OUT=1 they go accept -> DONE with latency 1):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return src1.
  - Signed overflow (src1 = -2^(XLEN-1), src2 = -1): DIV returns src1; REM returns 0.
- DONE state:
  - out_valid=1. result and rd_addr_o stay stable until out_ready=1.
  - On out_ready with no new accept, go to IDLE and set out_valid=0 the next cycle.
  - On out_ready with a simultaneous accept, go directly to the next op's state, giving back-to-back throughput. For a base op, out_valid stays 1 with the new result.
- flush:
  - From any state, the next state is IDLE with out_valid=0 and busy=0.
  - A result in DONE is dropped even if out_ready=1 in the same cycle.
  - No operation is accepted in a flush cycle.
  - The counter and partial product/remainder are not required to be cleared, but they must not leak into a later result.
- result and rd_addr_o hold their last values while out_valid=0.
- busy=1 exactly in MUL and DIV.
- in_valid arriving while busy is not accepted and is not lost: the upstream holds it until in_ready.

Test Plan:
- Reset and base ops: assert rst for 2 cycles, then apply ADD with src1=7, src2=0xFFFF_FFFF, then SRA (funct=4'b1101) with src1=0x8000_0000, src2=4.
  - During reset: out_valid=0 and result=0.
  - ADD: result=6, one cycle after accept.
  - SRA: result=0xF800_0000.
  - Back-to-back with out_ready tied high: in_ready stays 1 and one result is produced per clock.
- Multiply: MULH with src1=0xFFFF_FFFE (-2), src2=3, then MULHU with 0xFFFF_FFFF × 0xFFFF_FFFF.
  - MULH: out_valid exactly 33 clocks after accept; result=0xFFFF_FFFF.
  - MULHU: result=0xFFFF_FFFE; MUL on the same operands gives 0x0000_0001.
  - busy=1 for 32 cycles.
- Divide signs: DIV with -7 / 2 → 0xFFFF_FFFD (-3); REM with -7 / 2 → 0xFFFF_FFFF (-1); REMU with 7 / 2 → 1. Each has latency 33.
- Special cases with EARLY_OUT=1, then EARLY_OUT=0:
  - DIVU with x/0 → 0xFFFF_FFFF.
  - REM with 5/0 → 5.
  - DIV with 0x8000_0000 / -1 → 0x8000_0000.
  - Latency is 1 with EARLY_OUT=1 and 33 with EARLY_OUT=0, with identical values.
- Backpressure and flush:
  - Complete a DIV while out_ready=0 for 5 cycles: result is stable and in_ready=0 throughout.
  - Assert flush on cycle 10 of a MUL: the next cycle is IDLE and out_valid never rises.
  - The following ADD (src1=1, src2=1) returns 2 with latency 1.
- Mid-operation reset and XLEN=64: assert rst during a DIV and confirm all outputs return to 0 the next cycle. Then, with XLEN=64, run MULHU with 2^63 × 4 and confirm result=2 and latency 65.
